// File: rtl/sargantana_set_ram_ctrl_if.sv
// Bundle between the icache FSM / set RAM and the set RAM controller.
// The slave modport is the controller's view; the master modport is its environment's view.
interface sargantana_set_ram_ctrl_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 6
);
    logic              flush_i;
    logic              flush_busy_o;
    logic              flush_done_o;
    logic              wr_valid_i;
    logic              wr_ready_o;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              rd_valid_i;
    logic              rd_ready_o;
    logic [ADDR_W-1:0] rd_addr_i;
    logic              rd_valid_o;
    logic [DATA_W-1:0] rd_data_o;
    logic              ram_req_o;
    logic              ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_data_o;
    logic [DATA_W-1:0] ram_data_i;

    modport slave (
        input  flush_i, wr_valid_i, wr_addr_i, wr_data_i, rd_valid_i, rd_addr_i, ram_data_i,
        output flush_busy_o, flush_done_o, wr_ready_o, rd_ready_o, rd_valid_o, rd_data_o,
               ram_req_o, ram_we_o, ram_addr_o, ram_data_o
    );

    modport master (
        output flush_i, wr_valid_i, wr_addr_i, wr_data_i, rd_valid_i, rd_addr_i, ram_data_i,
        input  flush_busy_o, flush_done_o, wr_ready_o, rd_ready_o, rd_valid_o, rd_data_o,
               ram_req_o, ram_we_o, ram_addr_o, ram_data_o
    );
endinterface

// File: rtl/sargantana_set_ram_ctrl.sv
// Single-port set RAM controller: flush sweep > refill write > lookup read, one op per cycle.
// Optional SET_RAM_CTRL_INIT_ON_RESET_EN: sweep the array automatically after reset release.
module sargantana_set_ram_ctrl #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    sargantana_set_ram_ctrl_if.slave    bus
);

    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PRE_LAST = ADDR_W'((DEPTH > 1) ? DEPTH - 2 : 0);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_rd_vld_p1;

    logic w_idle;
    logic w_flush_req;
    logic w_init;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_sweep;

`ifdef SET_RAM_CTRL_INIT_ON_RESET_EN
    logic r_init;

    // Pending auto-sweep request, consumed on the first edge after reset release.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            r_init <= 1'b1;
        else if (r_state == IDLE)
            r_init <= 1'b0;
    end

    assign w_init = r_init;
`else
    assign w_init = 1'b0;
`endif

    assign w_idle      = (r_state == IDLE);
    assign w_sweep     = (r_state == FLUSH);
    assign w_flush_req = bus.flush_i | w_init;

    // A flush request in IDLE takes the cycle; neither client is served.
    assign bus.wr_ready_o = rstn_i & w_idle & ~w_flush_req;
    assign bus.rd_ready_o = rstn_i & w_idle & ~w_flush_req & ~bus.wr_valid_i;

    assign w_wr_acc = bus.wr_valid_i & bus.wr_ready_o;
    assign w_rd_acc = bus.rd_valid_i & bus.rd_ready_o;

    assign bus.ram_req_o  = w_sweep | w_wr_acc | w_rd_acc;
    assign bus.ram_we_o   = w_sweep | w_wr_acc;
    assign bus.ram_addr_o = w_sweep  ? r_cnt         :
                            w_wr_acc ? bus.wr_addr_i :
                            w_rd_acc ? bus.rd_addr_i : '0;
    assign bus.ram_data_o = w_wr_acc ? bus.wr_data_i : '0;

    assign bus.rd_data_o    = bus.ram_data_i;
    assign bus.rd_valid_o   = r_rd_vld_p1;
    assign bus.flush_busy_o = r_busy;
    assign bus.flush_done_o = r_done;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_vld_p1 <= 1'b0;
        end else begin
            // p0 -> p1: RAM returns read data one cycle after the accepted request
            r_rd_vld_p1 <= w_rd_acc;
            case (r_state)
                IDLE: begin
                    if (w_flush_req) begin
                        r_state <= FLUSH;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= (DEPTH == 1);
                    end
                end
                FLUSH: begin
                    // flush_i is deliberately not looked at here: a sweep is never restarted.
                    if (r_cnt == LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else begin
                        r_cnt  <= r_cnt + ADDR_W'(1);
                        r_done <= (r_cnt == PRE_LAST);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
